vec_exe_stage: RTL and testbench

- Execute stage of the vector encryption pipeline. It consumes the ID/EXE register outputs and drives the EXE/MEM register.
- Inputs are four 16-bit vector lanes plus one scalar operand pair.
- Single-cycle ALU ops produce a registered result one cycle after issue.
- MUL runs as a multi-cycle shift-add operation. While it runs, the block stalls the ID/EXE register and inserts bubbles downstream.

---
 rtl/vec_exe_pkg.sv | 37 +++
 rtl/vec_exe_stage_mul.sv | 45 ++++
 rtl/vec_exe_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_vec_exe_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_exe_pkg.sv
// Shared types for the vector encryption execute stage: ALU opcodes, FSM states
// and the control bundle carried alongside each instruction.
package vec_exe_pkg;

  localparam int LANES = 4;
  localparam int UNITS = LANES + 1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SHL  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_ROL  = 4'h7,
    ALU_ROR  = 4'h8,
    ALU_MUL  = 4'h9,
    ALU_PASS = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exe_state_e;

  typedef struct packed {
    logic [3:0] rd;
    logic       reg_write;
    logic       mem_write;
    logic       result_src;
    logic       update_count;
    logic       branch_taken;
  } ctrl_t;

endpackage

// File: rtl/vec_exe_stage_mul.sv
// One iterative shift-add multiplier (low WIDTH bits of the product); the
// execute stage instantiates one per lane plus one for the scalar pair.
module lane_mul_seq
  import vec_exe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] prod_r;

  // Operand latch on start, then one add-and-shift per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
    end else if (en) begin
      if (start) begin
        mcand_r  <= a;
        mplier_r <= b;
        prod_r   <= {WIDTH{1'b0}};
      end else if (step) begin
        if (mplier_r[0]) begin
          prod_r <= prod_r + mcand_r;
        end
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
      end
    end
  end

  assign product = prod_r;

endmodule

// File: rtl/vec_exe_stage.sv
// Execute stage: four vector lanes plus a scalar pair, single-cycle ALU and an
// iterative MUL that stalls upstream. Define VEC_SAT_EN for saturating ADD/SUB.
module vec_exe_stage
  import vec_exe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             flush,
  input  logic [WIDTH-1:0] op01_in,
  input  logic [WIDTH-1:0] op11_in,
  input  logic [WIDTH-1:0] op21_in,
  input  logic [WIDTH-1:0] op31_in,
  input  logic [WIDTH-1:0] op02_in,
  input  logic [WIDTH-1:0] op12_in,
  input  logic [WIDTH-1:0] op22_in,
  input  logic [WIDTH-1:0] op32_in,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       rd_in,
  input  logic [3:0]       aluControl_in,
  input  logic             regWrite_in,
  input  logic             memWrite_in,
  input  logic             branch_in,
  input  logic             resultSrc_in,
  input  logic             updateCount_in,
  output logic [WIDTH-1:0] res0_out,
  output logic [WIDTH-1:0] res1_out,
  output logic [WIDTH-1:0] res2_out,
  output logic [WIDTH-1:0] res3_out,
  output logic [WIDTH-1:0] sres_out,
  output logic [WIDTH-1:0] op2_out,
  output logic [3:0]       rd_out,
  output logic             regWrite_out,
  output logic             memWrite_out,
  output logic             resultSrc_out,
  output logic             updateCount_out,
  output logic             branchTaken_out,
  output logic             stall_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] alu_calc(input alu_op_e op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0]   calc;
    logic [2*WIDTH-1:0] dbl;
    logic [3:0]         sh;
`ifdef VEC_SAT_EN
    logic [WIDTH:0]     ext;
`endif
    calc = {WIDTH{1'b0}};
    dbl  = {(2*WIDTH){1'b0}};
    sh   = b[3:0];
    case (op)
`ifdef VEC_SAT_EN
      ALU_ADD: begin
        ext  = {1'b0, a} + {1'b0, b};
        calc = ext[WIDTH] ? {WIDTH{1'b1}} : ext[WIDTH-1:0];
      end
      ALU_SUB: calc = (a < b) ? {WIDTH{1'b0}} : (a - b);
`else
      ALU_ADD: calc = a + b;
      ALU_SUB: calc = a - b;
`endif
      ALU_AND: calc = a & b;
      ALU_OR:  calc = a | b;
      ALU_XOR: calc = a ^ b;
      ALU_SHL: calc = a << sh;
      ALU_SHR: calc = a >> sh;
      ALU_ROL: begin
        dbl  = {a, a} << sh;
        calc = dbl[2*WIDTH-1:WIDTH];
      end
      ALU_ROR: begin
        dbl  = {a, a} >> sh;
        calc = dbl[WIDTH-1:0];
      end
      ALU_PASS: calc = a;
      default:  calc = {WIDTH{1'b0}};
    endcase
    return calc;
  endfunction

  exe_state_e       state_r, state_n;
  logic [CW-1:0]    count_r, count_n;
  logic             load_alu, load_mul, mul_start, mul_step;
  logic             is_mul;
  ctrl_t            ctrl_in, ctrl_held_r, ctrl_out_r;
  logic [WIDTH-1:0] op2_held_r, op2_out_r;
  logic [WIDTH-1:0] opa [UNITS];
  logic [WIDTH-1:0] opb [UNITS];
  logic [WIDTH-1:0] alu_res [UNITS];
  logic [WIDTH-1:0] prod [UNITS];
  logic [WIDTH-1:0] res_r [UNITS];

  assign opa[0] = op01_in;
  assign opa[1] = op11_in;
  assign opa[2] = op21_in;
  assign opa[3] = op31_in;
  assign opa[4] = op1;
  assign opb[0] = op02_in;
  assign opb[1] = op12_in;
  assign opb[2] = op22_in;
  assign opb[3] = op32_in;
  assign opb[4] = op2;

  assign is_mul  = (aluControl_in == ALU_MUL);
  assign ctrl_in = '{rd: rd_in, reg_write: regWrite_in, mem_write: memWrite_in,
                     result_src: resultSrc_in, update_count: updateCount_in,
                     branch_taken: branch_in & (op1 == op2)};

  // Same operation on every lane and on the scalar pair.
  always_comb begin
    for (int i = 0; i < UNITS; i++) begin
      alu_res[i] = alu_calc(alu_op_e'(aluControl_in), opa[i], opb[i]);
    end
  end

  for (genvar g = 0; g < UNITS; g++) begin : g_mul
    lane_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .en      (~stop),
      .start   (mul_start),
      .step    (mul_step),
      .a       (opa[g]),
      .b       (opb[g]),
      .product (prod[g])
    );
  end

  // Next-state and load selection; flush outranks a new issue.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    if (flush) begin
      state_n = IDLE;
      count_n = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (is_mul) begin
            mul_start = 1'b1;
            count_n   = {CW{1'b0}};
            state_n   = BUSY;
          end else begin
            load_alu = 1'b1;
          end
        end
        BUSY: begin
          mul_step = 1'b1;
          if (count_r == LAST_ITER) begin
            state_n = DONE;
          end else begin
            count_n = count_r + CW'(1);
          end
        end
        DONE: begin
          load_mul = 1'b1;
          state_n  = IDLE;
        end
        default: begin
          state_n = IDLE;
          count_n = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, held MUL context and EXE/MEM outputs; stop freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      ctrl_held_r <= '0;
      ctrl_out_r  <= '0;
      op2_held_r  <= {WIDTH{1'b0}};
      op2_out_r   <= {WIDTH{1'b0}};
      for (int i = 0; i < UNITS; i++) begin
        res_r[i] <= {WIDTH{1'b0}};
      end
    end else if (!stop) begin
      state_r <= state_n;
      count_r <= count_n;
      if (mul_start) begin
        ctrl_held_r <= ctrl_in;
        op2_held_r  <= op2;
      end
      if (load_alu) begin
        ctrl_out_r <= ctrl_in;
        op2_out_r  <= op2;
        for (int i = 0; i < UNITS; i++) begin
          res_r[i] <= alu_res[i];
        end
      end else if (load_mul) begin
        ctrl_out_r <= ctrl_held_r;
        op2_out_r  <= op2_held_r;
        for (int i = 0; i < UNITS; i++) begin
          res_r[i] <= prod[i];
        end
      end else begin
        // Bubble: flags cleared, data left as they were.
        ctrl_out_r <= '{rd: ctrl_out_r.rd, default: 1'b0};
      end
    end
  end

  assign stall_out       = stop | ((state_r == IDLE) & is_mul) | (state_r == BUSY);
  assign res0_out        = res_r[0];
  assign res1_out        = res_r[1];
  assign res2_out        = res_r[2];
  assign res3_out        = res_r[3];
  assign sres_out        = res_r[4];
  assign op2_out         = op2_out_r;
  assign rd_out          = ctrl_out_r.rd;
  assign regWrite_out    = ctrl_out_r.reg_write;
  assign memWrite_out    = ctrl_out_r.mem_write;
  assign resultSrc_out   = ctrl_out_r.result_src;
  assign updateCount_out = ctrl_out_r.update_count;
  assign branchTaken_out = ctrl_out_r.branch_taken;

endmodule

// File: tb/tb_vec_exe_stage.sv
// Directed self-checking bench for vec_exe_stage (ALU ops, MUL timing, flush,
// stop, reset mid-MUL). Honors VEC_SAT_EN for the saturating ADD/SUB results.
module tb_vec_exe_stage;

  logic        clk = 1'b0;
  logic        reset, stop, flush;
  logic [15:0] op01_in, op11_in, op21_in, op31_in;
  logic [15:0] op02_in, op12_in, op22_in, op32_in;
  logic [15:0] op1, op2;
  logic [3:0]  rd_in, aluControl_in;
  logic        regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in;
  logic [15:0] res0_out, res1_out, res2_out, res3_out, sres_out, op2_out;
  logic [3:0]  rd_out;
  logic        regWrite_out, memWrite_out, resultSrc_out, updateCount_out;
  logic        branchTaken_out, stall_out;

  int n_cmp = 0;
  int n_err = 0;

`ifdef VEC_SAT_EN
  localparam logic [15:0] ADD_L0 = 16'hFFFF;
  localparam logic [15:0] SUB_L0 = 16'h0000;
`else
  localparam logic [15:0] ADD_L0 = 16'h0000;
  localparam logic [15:0] SUB_L0 = 16'hFFFE;
`endif

  vec_exe_stage dut (
    .clk(clk), .reset(reset), .stop(stop), .flush(flush),
    .op01_in(op01_in), .op11_in(op11_in), .op21_in(op21_in), .op31_in(op31_in),
    .op02_in(op02_in), .op12_in(op12_in), .op22_in(op22_in), .op32_in(op32_in),
    .op1(op1), .op2(op2), .rd_in(rd_in), .aluControl_in(aluControl_in),
    .regWrite_in(regWrite_in), .memWrite_in(memWrite_in), .branch_in(branch_in),
    .resultSrc_in(resultSrc_in), .updateCount_in(updateCount_in),
    .res0_out(res0_out), .res1_out(res1_out), .res2_out(res2_out), .res3_out(res3_out),
    .sres_out(sres_out), .op2_out(op2_out), .rd_out(rd_out),
    .regWrite_out(regWrite_out), .memWrite_out(memWrite_out),
    .resultSrc_out(resultSrc_out), .updateCount_out(updateCount_out),
    .branchTaken_out(branchTaken_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    op01_in = a0; op11_in = a1; op21_in = a2; op31_in = a3;
    op02_in = b0; op12_in = b1; op22_in = b2; op32_in = b3;
  endtask

  task automatic set_ctl(input logic [3:0] op, input logic [3:0] rd, input logic rw);
    aluControl_in = op;
    rd_in         = rd;
    regWrite_in   = rw;
  endtask

  initial begin
    reset = 1'b0; stop = 1'b0; flush = 1'b0;
    set_lanes(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    op1 = 16'h0; op2 = 16'h0;
    set_ctl(4'hB, 4'h0, 1'b0);
    memWrite_in = 1'b0; branch_in = 1'b0; resultSrc_in = 1'b0; updateCount_in = 1'b0;
    tick(); tick();
    check_val("rst_res0", res0_out, 16'h0000);
    check_val("rst_regwrite", {15'd0, regWrite_out}, 16'h0000);
    check_val("rst_stall", {15'd0, stall_out}, 16'h0000);

    // Reset in the middle of a MUL
    reset = 1'b1;
    set_lanes(16'd3, 16'd1, 16'd1, 16'd1, 16'd5, 16'd1, 16'd1, 16'd1);
    set_ctl(4'h9, 4'h1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check_val("mulrst_busy_stall", {15'd0, stall_out}, 16'h0001);
    reset = 1'b0;
    set_lanes(16'd2, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0);
    op1 = 16'd2; op2 = 16'd3;
    set_ctl(4'h0, 4'h2, 1'b1);
    #1;
    check_val("mulrst_res0", res0_out, 16'h0000);
    check_val("mulrst_sres", sres_out, 16'h0000);
    check_val("mulrst_regwrite", {15'd0, regWrite_out}, 16'h0000);
    check_val("mulrst_stall", {15'd0, stall_out}, 16'h0000);
    reset = 1'b1;
    tick();
    check_val("postrst_add_res0", res0_out, 16'd5);
    check_val("postrst_add_sres", sres_out, 16'd5);
    check_val("postrst_rd", {12'd0, rd_out}, 16'h0002);

    // ADD with lane-0 carry out
    set_lanes(16'hFFFF, 16'd7, 16'h1234, 16'd1, 16'd1, 16'd8, 16'h0000, 16'd1);
    op1 = 16'd2; op2 = 16'd2;
    set_ctl(4'h0, 4'h4, 1'b1);
    tick();
    check_val("add_res0", res0_out, ADD_L0);
    check_val("add_res1", res1_out, 16'd15);
    check_val("add_res2", res2_out, 16'h1234);
    check_val("add_res3", res3_out, 16'd2);
    check_val("add_sres", sres_out, 16'd4);
    check_val("add_op2out", op2_out, 16'd2);

    // MUL: 17 stall cycles, result on edge 18
    set_lanes(16'd3, 16'h0100, 16'hFFFF, 16'd0, 16'd5, 16'h0100, 16'd2, 16'd9);
    op1 = 16'd7; op2 = 16'd6;
    set_ctl(4'h9, 4'h9, 1'b1);
    #1;
    for (int e = 1; e <= 18; e++) begin
      check_val($sformatf("mul_stall_e%0d", e), {15'd0, stall_out}, (e <= 17) ? 16'h0001 : 16'h0000);
      tick();
      if (e == 1) begin
        rd_in = 4'h3;
        check_val("mul_bubble_keeps_res0", res0_out, ADD_L0);
      end
      if (e < 18) check_val($sformatf("mul_regwrite_e%0d", e), {15'd0, regWrite_out}, 16'h0000);
    end
    check_val("mul_res0", res0_out, 16'd15);
    check_val("mul_res1", res1_out, 16'h0000);
    check_val("mul_res2", res2_out, 16'hFFFE);
    check_val("mul_res3", res3_out, 16'h0000);
    check_val("mul_sres", sres_out, 16'd42);
    check_val("mul_rd", {12'd0, rd_out}, 16'h0009);
    check_val("mul_regwrite", {15'd0, regWrite_out}, 16'h0001);
    check_val("mul_op2out", op2_out, 16'd6);

    // Shifts, rotates, SUB, reserved op
    set_ctl(4'h7, 4'h1, 1'b1);
    set_lanes(16'h8001, 16'h0, 16'h0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0);
    tick();
    check_val("rol_res0", res0_out, 16'h0003);
    set_ctl(4'h8, 4'h1, 1'b1);
    set_lanes(16'h1234, 16'h0, 16'h0, 16'h0, 16'd4, 16'h0, 16'h0, 16'h0);
    tick();
    check_val("ror_res0", res0_out, 16'h4123);
    set_ctl(4'h6, 4'h1, 1'b1);
    set_lanes(16'h8000, 16'h0, 16'h0, 16'h0, 16'd15, 16'h0, 16'h0, 16'h0);
    tick();
    check_val("shr_res0", res0_out, 16'h0001);
    set_ctl(4'h1, 4'h1, 1'b1);
    set_lanes(16'd5, 16'h0, 16'h0, 16'h0, 16'd7, 16'h0, 16'h0, 16'h0);
    op1 = 16'hF0F0; op2 = 16'h00F0;
    tick();
    check_val("sub_res0", res0_out, SUB_L0);
    check_val("sub_sres", sres_out, 16'hF000);
    set_ctl(4'hB, 4'h1, 1'b1);
    tick();
    check_val("rsvd_sres", sres_out, 16'h0000);
    check_val("rsvd_regwrite", {15'd0, regWrite_out}, 16'h0001);

    // Branch compare
    set_ctl(4'h0, 4'h0, 1'b0);
    branch_in = 1'b1; op1 = 16'h00AA; op2 = 16'h00AA;
    tick();
    check_val("br_equal", {15'd0, branchTaken_out}, 16'h0001);
    op2 = 16'h00AB;
    tick();
    check_val("br_noteq", {15'd0, branchTaken_out}, 16'h0000);
    branch_in = 1'b0; op2 = 16'h00AA;
    tick();
    check_val("br_disabled", {15'd0, branchTaken_out}, 16'h0000);

    // Flush on cycle 6 of a MUL
    set_ctl(4'hA, 4'h0, 1'b0);
    set_lanes(16'h5A5A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    check_val("pass_res0", res0_out, 16'h5A5A);
    set_ctl(4'h9, 4'h6, 1'b1);
    set_lanes(16'd3, 16'h0, 16'h0, 16'h0, 16'd5, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_ctl(4'hB, 4'h0, 1'b0);
    #1;
    check_val("flush_stall", {15'd0, stall_out}, 16'h0000);
    check_val("flush_regwrite", {15'd0, regWrite_out}, 16'h0000);
    check_val("flush_keeps_res0", res0_out, 16'h5A5A);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val($sformatf("flush_noproduct_%0d", i), {15'd0, regWrite_out}, 16'h0000);
    end

    // Stop for 3 cycles mid-MUL delays the result by 3 edges
    set_ctl(4'h9, 4'h7, 1'b1);
    set_lanes(16'd3, 16'h0, 16'h0, 16'h0, 16'd5, 16'h0, 16'h0, 16'h0);
    for (int e = 1; e <= 21; e++) begin
      if (e == 6) stop = 1'b1;
      if (e == 9) stop = 1'b0;
      #1;
      if (stop) check_val($sformatf("stop_stall_e%0d", e), {15'd0, stall_out}, 16'h0001);
      tick();
      if (e < 21) check_val($sformatf("stop_regwrite_e%0d", e), {15'd0, regWrite_out}, 16'h0000);
    end
    set_ctl(4'hB, 4'h0, 1'b0);
    check_val("stop_mul_res0", res0_out, 16'd15);
    check_val("stop_mul_regwrite", {15'd0, regWrite_out}, 16'h0001);
    check_val("stop_mul_rd", {12'd0, rd_out}, 16'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
